// File: rtl/sdram_bist.sv
// sdram_bist: SDRAM built-in self-test sequencer.
// The sequencer writes a pattern over [addr_first..addr_last], then reads the
// range back and compares each word against the same pattern. It records the
// error count and the address/data of the first failing word.
//
// Optional feature macro: UART_REPORT_EN. When it is defined, an 8-byte summary
// frame goes out on tx_byte/tx_en before done. When it is undefined, tx_byte and
// tx_en are tied to 0 and tx_ready is ignored.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   start               one-cycle pulse, starts a run when idle
//   mode                pattern: 0 incr, 1 addr-as-data, 2 walking one, 3 LFSR
//   stop_on_error       end the run at the first miscompare
//   addr_first/last     inclusive address range, sampled at start
//   busy, done          run in progress / one-cycle end pulse
//   fail, timeout       error seen / read timeout seen (held until next start)
//   err_count           saturating error count
//   first_err_addr/data address and read data of the first error
//   mem_cmd_*           command port to the SDRAM controller
//   mem_rd_data/valid   read return from the SDRAM controller
//   tx_byte/tx_en/tx_ready  UART report interface
module sdram_bist #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ERR_W      = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
    parameter int unsigned RD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stop_on_error,
    input  logic [ADDR_W-1:0] addr_first,
    input  logic [ADDR_W-1:0] addr_last,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_enable,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_address,
    output logic [DATA_W-1:0] mem_cmd_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_en,
    input  logic              tx_ready
);

    localparam int unsigned TMR_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // taps 32,22,2,1

`ifdef UART_REPORT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_ACK, S_RD_REQ, S_RD_DATA, S_REPORT, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_ACK, S_RD_REQ, S_RD_DATA, S_DONE
    } state_t;
`endif

    state_t            state, state_nx;
    logic              busy_nx, done_nx, fail_nx, timeout_nx;
    logic [ERR_W-1:0]  err_count_nx;
    logic [ADDR_W-1:0] first_err_addr_nx;
    logic [DATA_W-1:0] first_err_data_nx;
    logic              mem_cmd_enable_nx, mem_cmd_wr_nx;
    logic [ADDR_W-1:0] mem_cmd_address_nx;
    logic [DATA_W-1:0] mem_cmd_data_nx;

    // Run configuration latched at start
    logic [1:0]        mode_q, mode_nx;
    logic              stop_q, stop_nx;
    logic [ADDR_W-1:0] first_q, first_nx, last_q, last_nx;

    // Pattern generators; all three step together once per access
    logic [DATA_W-1:0] inc_q, inc_nx, walk_q, walk_nx;
    logic [31:0]       lfsr_q, lfsr_nx;
    logic [TMR_W-1:0]  tmr_q, tmr_nx;

    logic              finish, advance, err_hit, err_to;
    logic [DATA_W-1:0] err_data, rd_exp;
    logic [DATA_W-1:0] inc_step, walk_step;
    logic [31:0]       lfsr_step;
    logic [ADDR_W-1:0] addr_inc;

`ifdef UART_REPORT_EN
    logic [2:0]  rep_idx, rep_idx_nx;
    logic [1:0]  rep_ph, rep_ph_nx;
    logic [7:0]  tx_byte_nx, rep_byte;
    logic        tx_en_nx;
    logic [15:0] err16;
    logic [23:0] addr24;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
    assign tx_byte         = 8'd0;
    assign tx_en           = 1'b0;
`endif

    // Galois right-shift LFSR step
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Pattern word selected by mode from the generator values for this access
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] inc,
                                                  input logic [DATA_W-1:0] walk,
                                                  input logic [31:0] lfsr);
        case (m)
            2'd0:    return inc;
            2'd1:    return DATA_W'(a);
            2'd2:    return walk;
            default: return DATA_W'(lfsr);
        endcase
    endfunction

`ifdef UART_REPORT_EN
    // Summary frame byte selection
    always_comb begin
        err16  = 16'(err_count);
        addr24 = 24'(first_err_addr);
        case (rep_idx)
            3'd0:    rep_byte = 8'hA5;
            3'd1:    rep_byte = {6'b0, timeout, fail};
            3'd2:    rep_byte = err16[15:8];
            3'd3:    rep_byte = err16[7:0];
            3'd4:    rep_byte = addr24[23:16];
            3'd5:    rep_byte = addr24[15:8];
            3'd6:    rep_byte = addr24[7:0];
            default: rep_byte = 8'h5A;
        endcase
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nx           = state;
        busy_nx            = busy;
        done_nx            = 1'b0;
        fail_nx            = fail;
        timeout_nx         = timeout;
        err_count_nx       = err_count;
        first_err_addr_nx  = first_err_addr;
        first_err_data_nx  = first_err_data;
        mem_cmd_enable_nx  = mem_cmd_enable;
        mem_cmd_wr_nx      = mem_cmd_wr;
        mem_cmd_address_nx = mem_cmd_address;
        mem_cmd_data_nx    = mem_cmd_data;
        mode_nx            = mode_q;
        stop_nx            = stop_q;
        first_nx           = first_q;
        last_nx            = last_q;
        inc_nx             = inc_q;
        walk_nx            = walk_q;
        lfsr_nx            = lfsr_q;
        tmr_nx             = tmr_q;
        finish             = 1'b0;
        advance            = 1'b0;
        err_hit            = 1'b0;
        err_to             = 1'b0;
        err_data           = '0;
`ifdef UART_REPORT_EN
        rep_idx_nx         = rep_idx;
        rep_ph_nx          = rep_ph;
        tx_byte_nx         = tx_byte;
        tx_en_nx           = 1'b0;
`endif
        inc_step  = inc_q + DATA_W'(1);
        walk_step = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
        lfsr_step = lfsr_adv(lfsr_q);
        addr_inc  = mem_cmd_address + ADDR_W'(1);
        rd_exp    = pattern(mode_q, mem_cmd_address, inc_q, walk_q, lfsr_q);

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nx            = mode;
                    stop_nx            = stop_on_error;
                    first_nx           = addr_first;
                    last_nx            = addr_last;
                    fail_nx            = 1'b0;
                    timeout_nx         = 1'b0;
                    err_count_nx       = '0;
                    first_err_addr_nx  = '0;
                    first_err_data_nx  = '0;
                    inc_nx             = DATA_W'(LFSR_SEED);
                    walk_nx            = DATA_W'(1);
                    lfsr_nx            = LFSR_SEED;
                    mem_cmd_address_nx = addr_first;
                    if (addr_first > addr_last) begin
                        fail_nx = 1'b1;
                        finish  = 1'b1;
                    end else begin
                        busy_nx           = 1'b1;
                        state_nx          = S_WR_REQ;
                        mem_cmd_enable_nx = 1'b1;
                        mem_cmd_wr_nx     = 1'b1;
                        mem_cmd_data_nx   = pattern(mode, addr_first, DATA_W'(LFSR_SEED),
                                                    DATA_W'(1), LFSR_SEED);
                    end
                end
            end
            S_WR_REQ: begin
                if (mem_cmd_ready) begin
                    mem_cmd_enable_nx = 1'b0;
                    state_nx          = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (mem_cmd_ready) begin
                    mem_cmd_enable_nx = 1'b1;
                    if (mem_cmd_address == last_q) begin
                        // Write pass complete: re-seed generators for the read pass
                        mem_cmd_wr_nx      = 1'b0;
                        mem_cmd_address_nx = first_q;
                        inc_nx             = DATA_W'(LFSR_SEED);
                        walk_nx            = DATA_W'(1);
                        lfsr_nx            = LFSR_SEED;
                        state_nx           = S_RD_REQ;
                    end else begin
                        mem_cmd_wr_nx      = 1'b1;
                        mem_cmd_address_nx = addr_inc;
                        inc_nx             = inc_step;
                        walk_nx            = walk_step;
                        lfsr_nx            = lfsr_step;
                        mem_cmd_data_nx    = pattern(mode_q, addr_inc, inc_step,
                                                     walk_step, lfsr_step);
                        state_nx           = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (mem_cmd_ready) begin
                    mem_cmd_enable_nx = 1'b0;
                    tmr_nx            = '0;
                    state_nx          = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (mem_rd_valid) begin
                    err_hit  = (mem_rd_data != rd_exp);
                    err_data = mem_rd_data;
                    advance  = 1'b1;
                end else if (tmr_q == TMR_W'(RD_TIMEOUT - 1)) begin
                    err_hit = 1'b1;
                    err_to  = 1'b1;
                    advance = 1'b1;
                end else begin
                    tmr_nx = tmr_q + TMR_W'(1);
                end
                if (err_hit) begin
                    // fail is still clear only before the first error of this run
                    if (!fail) begin
                        first_err_addr_nx = mem_cmd_address;
                        first_err_data_nx = err_data;
                    end
                    fail_nx = 1'b1;
                    if (err_to) timeout_nx = 1'b1;
                    if (err_count != '1) err_count_nx = err_count + ERR_W'(1);
                end
                if (advance) begin
                    if ((err_hit && stop_q) || (mem_cmd_address == last_q)) begin
                        finish = 1'b1;
                    end else begin
                        mem_cmd_enable_nx  = 1'b1;
                        mem_cmd_wr_nx      = 1'b0;
                        mem_cmd_address_nx = addr_inc;
                        inc_nx             = inc_step;
                        walk_nx            = walk_step;
                        lfsr_nx            = lfsr_step;
                        state_nx           = S_RD_REQ;
                    end
                end
            end
`ifdef UART_REPORT_EN
            S_REPORT: begin
                // Phases: 0 wait tx_ready, 1 tx_en high, 2 idle gap
                case (rep_ph)
                    2'd0: begin
                        if (tx_ready) begin
                            tx_en_nx   = 1'b1;
                            tx_byte_nx = rep_byte;
                            rep_ph_nx  = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (rep_idx == 3'd7) begin
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = S_DONE;
                        end else begin
                            rep_ph_nx = 2'd2;
                        end
                    end
                    default: begin
                        rep_ph_nx  = 2'd0;
                        rep_idx_nx = rep_idx + 3'd1;
                    end
                endcase
            end
`endif
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Common end-of-run path
        if (finish) begin
            mem_cmd_enable_nx = 1'b0;
`ifdef UART_REPORT_EN
            busy_nx    = 1'b1;
            rep_idx_nx = 3'd0;
            rep_ph_nx  = 2'd0;
            state_nx   = S_REPORT;
`else
            busy_nx    = 1'b0;
            done_nx    = 1'b1;
            state_nx   = S_DONE;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
            mem_cmd_enable  <= 1'b0;
            mem_cmd_wr      <= 1'b0;
            mem_cmd_address <= '0;
            mem_cmd_data    <= '0;
            mode_q          <= 2'd0;
            stop_q          <= 1'b0;
            first_q         <= '0;
            last_q          <= '0;
            inc_q           <= '0;
            walk_q          <= '0;
            lfsr_q          <= '0;
            tmr_q           <= '0;
`ifdef UART_REPORT_EN
            rep_idx         <= 3'd0;
            rep_ph          <= 2'd0;
            tx_byte         <= 8'd0;
            tx_en           <= 1'b0;
`endif
        end else begin
            state           <= state_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            fail            <= fail_nx;
            timeout         <= timeout_nx;
            err_count       <= err_count_nx;
            first_err_addr  <= first_err_addr_nx;
            first_err_data  <= first_err_data_nx;
            mem_cmd_enable  <= mem_cmd_enable_nx;
            mem_cmd_wr      <= mem_cmd_wr_nx;
            mem_cmd_address <= mem_cmd_address_nx;
            mem_cmd_data    <= mem_cmd_data_nx;
            mode_q          <= mode_nx;
            stop_q          <= stop_nx;
            first_q         <= first_nx;
            last_q          <= last_nx;
            inc_q           <= inc_nx;
            walk_q          <= walk_nx;
            lfsr_q          <= lfsr_nx;
            tmr_q           <= tmr_nx;
`ifdef UART_REPORT_EN
            rep_idx         <= rep_idx_nx;
            rep_ph          <= rep_ph_nx;
            tx_byte         <= tx_byte_nx;
            tx_en           <= tx_en_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: directed and randomized runs of sdram_bist against a behavioural
// memory with injectable faults. Expected results come from a per-address model
// of the pattern rules.
module tb_sdram_bist;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst, start, stop_on_error;
    logic [1:0]  mode;
    logic [22:0] addr_first, addr_last;
    logic        busy, done, fail, timeout;
    logic [15:0] err_count;
    logic [22:0] first_err_addr;
    logic [31:0] first_err_data;
    logic        mem_cmd_ready, mem_cmd_enable, mem_cmd_wr;
    logic [22:0] mem_cmd_address;
    logic [31:0] mem_cmd_data, mem_rd_data;
    logic        mem_rd_valid;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_ready;

    always #5 clk = ~clk;

    sdram_bist dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stop_on_error(stop_on_error),
        .addr_first(addr_first), .addr_last(addr_last), .busy(busy), .done(done),
        .fail(fail), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_enable(mem_cmd_enable),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_address(mem_cmd_address),
        .mem_cmd_data(mem_cmd_data), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .tx_byte(tx_byte), .tx_en(tx_en),
        .tx_ready(tx_ready)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Fault configuration for the memory model
    bit          flip_en, stuck_en, drop_en;
    logic [22:0] flip_addr, stuck_a, stuck_b, drop_addr;

    function automatic logic [31:0] faulted(input logic [22:0] a, input logic [31:0] d);
        logic [31:0] v;
        v = d;
        if (stuck_en && (a == stuck_a || a == stuck_b)) v = 32'd0;
        if (flip_en && a == flip_addr) v = v ^ 32'd1;
        return v;
    endfunction

    // Memory responder: random ready, 1..4 cycle read latency, one read at a time
    logic [31:0] mem [0:1023];
    int          n_wr, n_rd, n_done, n_en, pend_cnt;
    logic [31:0] pend_data;

    always @(negedge clk) begin
        if (!rst) begin
            mem_cmd_ready = 1'b0;
            mem_rd_valid  = 1'b0;
            pend_cnt      = 0;
        end else begin
            mem_rd_valid = 1'b0;
            if (done) n_done++;
            if (mem_cmd_enable) n_en++;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = pend_data;
                end
            end
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
            if (mem_cmd_enable && mem_cmd_ready) begin
                if (mem_cmd_wr) begin
                    mem[mem_cmd_address[9:0]] = mem_cmd_data;
                    n_wr++;
                end else begin
                    n_rd++;
                    if (!(drop_en && mem_cmd_address == drop_addr)) begin
                        pend_cnt  = $urandom_range(1, 4);
                        pend_data = faulted(mem_cmd_address, mem[mem_cmd_address[9:0]]);
                    end
                end
            end
        end
    end

    // Reference: data expected at index i / address a of a run
    function automatic logic [31:0] pattern(input int m, input longint i, input logic [22:0] a);
        logic [31:0] s;
        case (m)
            0: return SEED + 32'(i);
            1: return {9'd0, a};
            2: return 32'd1 << (i % 32);
            default: begin
                s = SEED;
                for (longint k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
                return s;
            end
        endcase
    endfunction

    int          e_wr, e_rd, e_err;
    bit          e_fail, e_to;
    logic [22:0] e_faddr;
    logic [31:0] e_fdata;

    task automatic predict(input int m, input longint f, input longint l, input bit stop);
        logic [22:0] a;
        logic [31:0] d, rd;
        bit          bad;
        e_wr = (f > l) ? 0 : int'(l - f + 1);
        e_rd = 0; e_err = 0; e_fail = (f > l); e_to = 0; e_faddr = '0; e_fdata = '0;
        for (longint i = 0; i < longint'(e_wr); i++) begin
            a = 23'(f + i);
            d = pattern(m, i, a);
            e_rd++;
            if (drop_en && a == drop_addr) begin
                bad = 1'b1; rd = 32'd0; e_to = 1'b1;
            end else begin
                rd = faulted(a, d); bad = (rd != d);
            end
            if (bad) begin
                if (e_err == 0) begin e_faddr = a; e_fdata = rd; end
                e_err++;
                e_fail = 1'b1;
                if (stop) break;
            end
        end
    endtask

    task automatic run(input string tag, input int m, input logic [22:0] f,
                       input logic [22:0] l, input bit stop);
        int cyc;
        predict(m, longint'(f), longint'(l), stop);
        @(negedge clk);
        n_wr = 0; n_rd = 0; n_done = 0; n_en = 0;
        mode = 2'(m); addr_first = f; addr_last = l; stop_on_error = stop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (f <= l) chk({tag, ".busy_start"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".done"}, done, 1);
        if (f > l) chk({tag, ".done_latency_ok"}, (cyc <= 2), 1);
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".err_count"}, err_count, 64'(e_err));
        chk({tag, ".fail"}, fail, e_fail);
        chk({tag, ".timeout"}, timeout, e_to);
        chk({tag, ".first_err_addr"}, first_err_addr, e_faddr);
        chk({tag, ".first_err_data"}, first_err_data, e_fdata);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".done_pulses"}, 64'(n_done), 1);
        chk({tag, ".writes"}, 64'(n_wr), 64'(e_wr));
        chk({tag, ".reads"}, 64'(n_rd), 64'(e_rd));
        if (f > l) chk({tag, ".no_cmd"}, 64'(n_en), 0);
`ifndef UART_REPORT_EN
        chk({tag, ".tx_idle"}, {tx_en, tx_byte}, 0);
`endif
    endtask

    task automatic clear_faults;
        flip_en = 0; stuck_en = 0; drop_en = 0;
        flip_addr = '0; stuck_a = '0; stuck_b = '0; drop_addr = '0;
    endtask

    initial begin
        int          cyc, m, len;
        logic [22:0] f;
        bit          stop;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        clear_faults();
        rst = 1'b0; start = 1'b0; mode = 2'd0; stop_on_error = 1'b0;
        addr_first = '0; addr_last = '0; tx_ready = 1'b1;
        mem_rd_data = '0; mem_rd_valid = 1'b0; mem_cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {busy, done, fail, timeout, mem_cmd_enable, mem_cmd_wr}, 0);
        chk("reset.err_count", err_count, 0);
        rst = 1'b1;

        run("mode0_clean", 0, 23'd0, 23'd15, 1'b0);

        flip_en = 1; flip_addr = 23'h123;
        run("mode3_flip", 3, 23'h100, 23'h1FF, 1'b0);
        clear_faults();

        stuck_en = 1; stuck_a = 23'd5; stuck_b = 23'd9;
        run("mode1_stop", 1, 23'd0, 23'd15, 1'b1);
        clear_faults();

        drop_en = 1; drop_addr = 23'd3;
        run("mode2_timeout", 2, 23'd0, 23'd7, 1'b0);
        clear_faults();

        run("bad_range", 0, 23'd10, 23'd4, 1'b0);
        run("top_of_space", 1, 23'h7FFFF0, 23'h7FFFFF, 1'b0);
        run("single_word", 3, 23'd77, 23'd77, 1'b0);

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            m    = int'($urandom_range(0, 3));
            f    = 23'($urandom_range(0, 600));
            len  = int'($urandom_range(1, 40));
            stop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                flip_en   = 1;
                flip_addr = f + 23'($urandom_range(0, len - 1));
            end
            run($sformatf("rand%0d", r), m, f, f + 23'(len - 1), stop);
        end
        clear_faults();

        // Reset in the middle of the write pass
        @(negedge clk);
        mode = 2'd0; addr_first = 23'd0; addr_last = 23'd15; stop_on_error = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mem_cmd_enable && mem_cmd_wr && mem_cmd_address == 23'd3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst.write_seen", {mem_cmd_enable, mem_cmd_wr}, 2'b11);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.flags", {busy, done, fail, timeout, mem_cmd_enable, mem_cmd_wr}, 0);
        chk("midrst.addr_data", {mem_cmd_address, mem_cmd_data}, 0);
        chk("midrst.err", {err_count, first_err_addr, first_err_data}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst.stays_idle", {busy, mem_cmd_enable}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
